// File: rtl/pe_pkg.sv
// Shared definitions for the PE MAC engine: FSM state encoding and the
// default operand, address and partial-sum widths.
package pe_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_ACC_W  = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } pe_state_e;

endpackage

// File: rtl/pe_mac_datapath.sv
// MAC datapath: signed multiplier, partial-sum accumulator and the optional
// saturating adder. Build option: define PE_MAC_SAT_EN to clamp every
// accumulate to the signed ACC_W range; otherwise the accumulate wraps.
// Scratchpad data arrives one cycle after the read, so the accumulate enable
// is the read enable delayed by one cycle.
module pe_mac_datapath
    import pe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic [ACC_W-1:0]         psum_in_i,
    input  logic                     mac_en_i,
    input  logic [DATA_W-1:0]        ifmap_rdata_i,
    input  logic [DATA_W-1:0]        filt_rdata_i,
    output logic [ACC_W-1:0]         acc_o
);

    logic                     mac_vld_q;
    logic [ACC_W-1:0]         acc_q;
    logic [ACC_W-1:0]         acc_d;
    logic signed [2*DATA_W-1:0] ifmap_ext_s;
    logic signed [2*DATA_W-1:0] filt_ext_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic signed [ACC_W:0]      sum_s;

`ifdef PE_MAC_SAT_EN
    // Clamp an ACC_W+1 bit sum into the signed ACC_W range.
    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] sum);
        logic [ACC_W-1:0] res;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) begin
                res = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                res = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            res = sum[ACC_W-1:0];
        end
        return res;
    endfunction
`endif

    // Operands widened before multiplying so the product is exact.
    assign ifmap_ext_s = (2*DATA_W)'($signed(ifmap_rdata_i));
    assign filt_ext_s  = (2*DATA_W)'($signed(filt_rdata_i));
    assign prod_s      = ifmap_ext_s * filt_ext_s;
    assign prod_ext_s  = ACC_W'(prod_s);
    assign sum_s       = $signed({acc_q[ACC_W-1], acc_q}) + $signed({prod_ext_s[ACC_W-1], prod_ext_s});

    // Next accumulator value: wrapping or saturating add of the product.
    always_comb begin
        acc_d = acc_q;
`ifdef PE_MAC_SAT_EN
        acc_d = sat_acc(sum_s);
`else
        acc_d = sum_s[ACC_W-1:0];
`endif
    end

    // Track which cycle carries valid scratchpad data; reset drops an in-flight product.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_vld_q <= 1'b0;
        end else begin
            mac_vld_q <= mac_en_i;
        end
    end

    // Accumulator: seeded from psum_in on load, updated by each valid product.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (load_i) begin
            acc_q <= psum_in_i;
        end else if (mac_vld_q) begin
            acc_q <= acc_d;
        end else begin
            acc_q <= acc_q;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pe_mac_engine.sv
// PE MAC engine top: sequences one convolution pass over N scratchpad taps,
// hands the accumulated partial sum downstream with valid/ready and pulses
// done back to the read controller. Build option PE_MAC_SAT_EN selects a
// saturating accumulate inside pe_mac_datapath.
module pe_mac_engine
    import pe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   tap_cnt,
    input  logic [ACC_W-1:0]  psum_in,
    output logic              spad_ren,
    output logic [ADDR_W-1:0] spad_raddr,
    input  logic [DATA_W-1:0] ifmap_rdata,
    input  logic [DATA_W-1:0] filt_rdata,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid,
    input  logic              psum_ready,
    output logic              done,
    output logic              busy
);

    pe_state_e         state_q;
    pe_state_e         state_d;
    // One bit wider than the address so N = 2^ADDR_W needs no wrap.
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   n_d;
    logic [ADDR_W:0]   cnt_inc_s;

    assign cnt_inc_s = cnt_q + (ADDR_W+1)'(1);

    // Next-state, tap count and address counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                n_d   = tap_cnt;
                cnt_d = '0;
                if (tap_cnt != '0) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_RUN: begin
                if (cnt_inc_s == n_q) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc_s;
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (psum_ready) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                n_d     = '0;
            end
        endcase
    end

    // FSM and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
        end
    end

    // Outputs decode straight from the state register, so they are glitch-free.
    assign spad_ren   = (state_q == ST_RUN);
    assign spad_raddr = (state_q == ST_RUN) ? cnt_q[ADDR_W-1:0] : '0;
    assign psum_valid = (state_q == ST_OUT);
    assign done       = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);

    pe_mac_datapath #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_datapath (
        .clk           (clk),
        .rst           (rst),
        .load_i        (state_q == ST_LOAD),
        .psum_in_i     (psum_in),
        .mac_en_i      (spad_ren),
        .ifmap_rdata_i (ifmap_rdata),
        .filt_rdata_i  (filt_rdata),
        .acc_o         (psum_out)
    );

endmodule

// File: doc/pe_mac_engine.md
PE_MAC_ENGINE -- requirements
Module: pe_mac_engine

Interface
REQ-001 Parameter DATA_W, default 8, signed ifmap/filter operand width.
REQ-002 Parameter ADDR_W, default 4, scratchpad address width.
REQ-003 Parameter ACC_W, default 20, signed partial-sum width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin one convolution pass; driven by the upstream read controller's finish_read.
REQ-007 tap_cnt  input  ADDR_W+1  number of MAC taps N, 0..2^ADDR_W.
REQ-008 psum_in  input  ACC_W  incoming partial sum, signed.
REQ-009 spad_ren  output  1  scratchpad read enable.
REQ-010 spad_raddr  output  ADDR_W  common read address for ifmap and filter scratchpads.
REQ-011 ifmap_rdata, filt_rdata  input  DATA_W each  scratchpad read data, valid one cycle after spad_ren.
REQ-012 psum_out  output  ACC_W  accumulated partial sum.
REQ-013 psum_valid  output  1  psum_out valid, held until accepted.
REQ-014 psum_ready  input  1  downstream accepts psum_out.
REQ-015 done  output  1  one-cycle pulse to the upstream read controller's done input.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, DRAIN, OUT, DONE.
REQ-018 IDLE -> LOAD when start=1; start SHALL be ignored in all other states.
REQ-019 LOAD: tap_cnt latched to N and psum_in to acc, address counter cleared; then -> RUN if N>0, else -> OUT.
REQ-020 RUN: spad_ren=1, spad_raddr=k for k=0..N-1 on consecutive cycles; -> DRAIN after address N-1 issued.
REQ-021 A product issued at cycle t SHALL be added to acc at the edge ending cycle t+1: acc += signed(ifmap_rdata)*signed(filt_rdata), sign-extended to ACC_W.
REQ-022 DRAIN: one cycle for the final product; -> OUT.
REQ-023 OUT: psum_valid=1, psum_out=acc held stable; -> DONE on the cycle psum_ready=1; psum_ready outside OUT is ignored.
REQ-024 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-025 Latency with psum_ready tied high: start edge to psum_valid = N+3 cycles (N>0), 2 cycles (N=0).
REQ-026 N=2^ADDR_W SHALL issue all addresses with no counter wrap before DRAIN.
REQ-027 spad_ren=0 and spad_raddr=0 outside RUN.

Reset
REQ-028 rst SHALL force IDLE, acc=0, counter=0, and spad_ren, psum_valid, done, busy, psum_out all 0 on the next edge, including mid-RUN or mid-OUT; an in-flight product is discarded.

Configuration
REQ-029 Macro PE_MAC_SAT_EN defined: each accumulate SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; undefined: accumulate SHALL wrap modulo 2^ACC_W.

Structure
REQ-030 Package pe_pkg SHALL hold the FSM state enum and default DATA_W/ADDR_W/ACC_W constants.
REQ-031 Sub-module pe_mac_datapath SHALL contain multiplier, accumulator register, and the PE_MAC_SAT_EN logic; the top holds FSM and address counter.

Verification
REQ-032 N=3, psum_in=10, ifmap={1,2,3}, filt={4,5,6}, ready=1 -> psum_out=42, psum_valid at start+6, done one cycle after.
REQ-033 N=0, psum_in=-7 -> no spad_ren, psum_out=-7 at start+2, done pulses.
REQ-034 N=2, ifmap={-128,-128}, filt={-128,-128}, ACC_W=16, psum_in=0 -> 32767 with PE_MAC_SAT_EN, -32768 without.
REQ-035 psum_ready low 5 cycles in OUT -> psum_valid and psum_out stable 5 cycles, done only after acceptance; start pulses meanwhile ignored.
REQ-036 rst asserted at RUN address 2 of N=8 -> next cycle IDLE, all outputs 0; following start with N=1, psum_in=0, ifmap=3, filt=3 -> psum_out=9.
